// File: rtl/croc_gpio_in_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : croc_gpio_in_filter                                        |
// | Description : GPIO input conditioning. Per pin: a two-flop synchronizer, |
// |               an enable-gated glitch filter (a new level must be seen    |
// |               FilterCycles consecutive samples before it is accepted),   |
// |               and registered single-cycle rise/fall event pulses.        |
// |               testmode_i bypasses filtering on every pin.                |
// | Ports       : clk_i       - SoC clock                                    |
// |               rst_ni      - synchronous active-low reset                 |
// |               testmode_i  - 1 = all pins unfiltered pass-through         |
// |               pad_gpio_i  - raw pad levels (asynchronous to clk_i)       |
// |               filt_en_i   - per-pin filter enable (synchronous)          |
// |               gpio_o      - conditioned pin level                        |
// |               rise_o      - 1-cycle pulse when gpio_o[i] goes 0->1       |
// |               fall_o      - 1-cycle pulse when gpio_o[i] goes 1->0       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module croc_gpio_in_filter #(
  parameter int unsigned GpioCount    = 32,
  parameter int unsigned FilterCycles = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 testmode_i,
  input  logic [GpioCount-1:0] pad_gpio_i,
  input  logic [GpioCount-1:0] filt_en_i,
  output logic [GpioCount-1:0] gpio_o,
  output logic [GpioCount-1:0] rise_o,
  output logic [GpioCount-1:0] fall_o
);

  localparam int unsigned CNT_W = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(FilterCycles - 1);

  logic [GpioCount-1:0] r_s1;
  logic [GpioCount-1:0] r_s2;
  logic [GpioCount-1:0] r_stable;
  logic [GpioCount-1:0] r_rise;
  logic [GpioCount-1:0] r_fall;

  // Value each pin's stable flop takes on this edge; events are derived
  // from it so they line up with the cycle gpio_o first shows the new level.
  wire  [GpioCount-1:0] w_stable_next;

  for (genvar i = 0; i < GpioCount; i++) begin : g_pin
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_nxt;

    always_comb begin
      w_nxt      = r_stable[i];
      w_cnt_next = r_cnt;
      if (testmode_i || !filt_en_i[i]) begin
        w_nxt      = r_s2[i];
        w_cnt_next = '0;
      end else if (r_s2[i] == r_stable[i]) begin
        // Input agrees with the accepted level: any partial glitch is dropped.
        w_cnt_next = '0;
      end else if (r_cnt == c_CNT_MAX) begin
        w_nxt      = r_s2[i];
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end

    assign w_stable_next[i] = w_nxt;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
    end else begin
      r_s1     <= pad_gpio_i;
      r_s2     <= r_s1;
      r_stable <= w_stable_next;
      r_rise   <= ~r_stable & w_stable_next;
      r_fall   <= r_stable & ~w_stable_next;
    end
  end

  assign gpio_o = r_stable;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule
`default_nettype wire
